// File: rtl/alu_shift_rotate_pipe.sv
// Two-stage pipelined barrel shifter/rotator (SHL, SHR, SHRA, ROL, ROR) with valid/ready on both sides.
// Optional zero/carry flag outputs are enabled by defining SHIFT_FLAGS_EN.
module alu_shift_rotate_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
`ifdef SHIFT_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_carry
`endif
);

    localparam int SHW = $clog2(WIDTH);
    localparam int LO  = SHW / 2;
    localparam int HI  = SHW - LO;

    localparam logic [2:0] OP_SHL  = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHRA = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;

    // One partial barrel step; both stages reuse it with their own slice of the amount.
    function automatic logic [WIDTH-1:0] shift_val(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] v,
                                                   input logic [SHW-1:0] s);
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0]   r;
        dbl = '0;
        r   = v;
        case (op)
            OP_SHL:  r = v << s;
            OP_SHR:  r = v >> s;
            OP_SHRA: r = $signed(v) >>> s;
            OP_ROL: begin
                dbl = {v, v} << s;
                r   = dbl[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                dbl = {v, v} >> s;
                r   = dbl[WIDTH-1:0];
            end
            default: r = v;
        endcase
        return r;
    endfunction

`ifdef SHIFT_FLAGS_EN
    // Tracks the last bit pushed out by a shift step; a zero-length step keeps c.
    function automatic logic carry_step(input logic [2:0] op,
                                        input logic [WIDTH-1:0] v,
                                        input logic c,
                                        input logic [SHW-1:0] s);
        logic [WIDTH:0] ext;
        logic           r;
        ext = '0;
        r   = c;
        case (op)
            OP_SHL: begin
                ext = {c, v} << s;
                r   = ext[WIDTH];
            end
            OP_SHR: begin
                ext = {v, c} >> s;
                r   = ext[0];
            end
            OP_SHRA: begin
                ext = $signed({v, c}) >>> s;
                r   = ext[0];
            end
            default: r = c;
        endcase
        return r;
    endfunction
`endif

    logic             s1_valid_reg;
    logic [2:0]       s1_op_reg;
    logic             s1_oor_reg;
    logic [TAG_W-1:0] s1_tag_reg;
    logic [WIDTH-1:0] s1_val_reg;
    logic [HI-1:0]    s1_hi_reg;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_result_reg;
    logic [TAG_W-1:0] out_tag_reg;

    logic             s1_adv;
    logic             s2_adv;
    logic [SHW-1:0]   s1_amt;
    logic [SHW-1:0]   s2_amt;
    logic [WIDTH-1:0] s1_val_next;
    logic             s1_oor_next;
    logic [WIDTH-1:0] result_next;

    assign s2_adv   = !out_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    assign s1_amt      = {{HI{1'b0}}, in_b[LO-1:0]};
    assign s2_amt      = {s1_hi_reg, {LO{1'b0}}};
    assign s1_val_next = shift_val(in_op, in_a, s1_amt);
    assign s1_oor_next = |in_b[WIDTH-1:SHW];

    always_comb begin
        result_next = shift_val(s1_op_reg, s1_val_reg, s2_amt);
        if (s1_oor_reg) begin
            case (s1_op_reg)
                OP_SHL, OP_SHR: result_next = '0;
                // Stage 1 used an arithmetic shift, so its MSB is still the operand sign.
                OP_SHRA:        result_next = {WIDTH{s1_val_reg[WIDTH-1]}};
                default:        ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= '0;
            s1_oor_reg   <= 1'b0;
            s1_tag_reg   <= '0;
            s1_val_reg   <= '0;
            s1_hi_reg    <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_op_reg  <= in_op;
                s1_oor_reg <= s1_oor_next;
                s1_tag_reg <= in_tag;
                s1_val_reg <= s1_val_next;
                s1_hi_reg  <= in_b[SHW-1:LO];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_tag_reg    <= '0;
        end else if (s2_adv) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_result_reg <= result_next;
                out_tag_reg    <= s1_tag_reg;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_tag    = out_tag_reg;

`ifdef SHIFT_FLAGS_EN
    logic s1_carry_reg;
    logic s1_amt_nz_reg;
    logic out_zero_reg;
    logic out_carry_reg;
    logic carry_next;

    always_comb begin
        carry_next = 1'b0;
        case (s1_op_reg)
            OP_SHL, OP_SHR, OP_SHRA: begin
                if (s1_oor_reg)
                    carry_next = (s1_op_reg == OP_SHRA) ? s1_val_reg[WIDTH-1] : 1'b0;
                else
                    carry_next = carry_step(s1_op_reg, s1_val_reg, s1_carry_reg, s2_amt);
            end
            OP_ROL:  carry_next = s1_amt_nz_reg & result_next[0];
            OP_ROR:  carry_next = s1_amt_nz_reg & result_next[WIDTH-1];
            default: carry_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_carry_reg  <= 1'b0;
            s1_amt_nz_reg <= 1'b0;
        end else if (s1_adv && in_valid) begin
            s1_carry_reg  <= carry_step(in_op, in_a, 1'b0, s1_amt);
            s1_amt_nz_reg <= |in_b[SHW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_zero_reg  <= 1'b0;
            out_carry_reg <= 1'b0;
        end else if (s2_adv && s1_valid_reg) begin
            out_zero_reg  <= (result_next == '0);
            out_carry_reg <= carry_next;
        end
    end

    assign out_zero  = out_zero_reg;
    assign out_carry = out_carry_reg;
`endif

endmodule
